// File: rtl/keypad_matrix_scan_if.sv
// Key-event stream from the keypad scanner to its consumer.
// The master presents the FIFO head; the slave accepts it with key_ready.
interface keypad_matrix_scan_if #(
  parameter int CW = 4
);
  logic [CW-1:0] key_code;
  logic          key_repeat;
  logic          key_valid;
  logic          key_ready;

  modport master (output key_code, output key_repeat, output key_valid, input key_ready);
  modport slave  (input key_code, input key_repeat, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_matrix_scan.sv
// Matrix keypad scanner: drives one row low per slot, senses columns through a
// 2-flop synchroniser, classifies each full frame, debounces press/release,
// generates auto-repeat events and queues them in a small event FIFO.
module keypad_matrix_scan #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4,
  parameter int FIFO_DEPTH      = 8,
  localparam int CW             = $clog2(ROWS * COLS),
  localparam int FW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ROWS-1:0]       keyb_row,
  input  logic [COLS-1:0]       keyb_col,
  input  logic                  repeat_en,
  keypad_matrix_scan_if.master  evt,
  output logic [FW-1:0]         fifo_count,
  output logic                  overflow,
  output logic                  multi_key
);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int RIW = $clog2(ROWS);
  localparam int DBW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int HW  = $clog2(REPEAT_DELAY + 1);
  localparam int RW  = $clog2(REPEAT_RATE + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [COLS-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [DW-1:0]   div_q, div_d;
  logic [RIW-1:0]  row_idx_q, row_idx_d;
  logic [1:0]      frame_n_q, frame_n_d;
  logic [CW-1:0]   frame_code_q, frame_code_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   cand_q, cand_d;
  logic [DBW-1:0]  db_q, db_d, db_n;
  logic [HW-1:0]   held_q, held_d;
  logic [RW-1:0]   rate_q, rate_d, rate_n;
  logic            push_q, push_d, push_rep_q, push_rep_d;
  logic [CW-1:0]   push_code_q, push_code_d;
  logic            multi_q, multi_d, ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]   cnt_q, cnt_d;
  logic [CW:0]     mem_q [FIFO_DEPTH];
  logic [CW:0]     mem_d [FIFO_DEPTH];

  logic            sample, frame_end, match, fire, pop, full, wr_en;
  logic [1:0]      row_n, tot_n;
  logic [2:0]      sum_n;
  logic [CW-1:0]   row_col, row_code, tot_code;

  // Row drive: only the current row is pulled low
  always_comb begin
    keyb_row            = '1;
    keyb_row[row_idx_q] = 1'b0;
  end

  // Scan timing, column synchroniser and per-frame key accumulation
  always_comb begin
    col_s1_d     = keyb_col;
    col_s2_d     = col_s1_q;
    sample       = (div_q == DW'(SCAN_DIV - 1));
    frame_end    = sample && (row_idx_q == RIW'(ROWS - 1));
    row_n        = 2'd0;
    row_col      = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_s2_q[c]) begin
        if (row_n != 2'd2) row_n = row_n + 2'd1;
        row_col = CW'(c);
      end
    end
    row_code     = CW'(row_idx_q) * CW'(COLS) + row_col;
    sum_n        = {1'b0, frame_n_q} + {1'b0, row_n};
    tot_n        = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code     = (row_n != 2'd0) ? row_code : frame_code_q;
    div_d        = div_q + DW'(1);
    row_idx_d    = row_idx_q;
    frame_n_d    = frame_n_q;
    frame_code_d = frame_code_q;
    if (sample) begin
      div_d        = '0;
      row_idx_d    = (row_idx_q == RIW'(ROWS - 1)) ? '0 : row_idx_q + RIW'(1);
      frame_n_d    = tot_n;
      frame_code_d = tot_code;
    end
    if (frame_end) begin
      frame_n_d    = 2'd0;
      frame_code_d = '0;
    end
    multi_d = frame_end && (tot_n == 2'd2);
  end

  // Debounce / auto-repeat FSM, evaluated once per frame end
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    db_d        = db_q;
    db_n        = db_q + DBW'(1);
    held_d      = held_q;
    rate_d      = rate_q;
    rate_n      = rate_q + RW'(1);
    fire        = 1'b0;
    push_d      = 1'b0;
    push_code_d = cand_q;
    push_rep_d  = 1'b0;
    match       = (tot_n == 2'd1) && (tot_code == cand_q);
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (tot_n == 2'd1) begin
            cand_d      = tot_code;
            push_code_d = tot_code;
            if (DEBOUNCE_FRAMES == 1) begin
              push_d  = 1'b1;
              state_d = HELD;
              held_d  = '0;
              rate_d  = '0;
            end else begin
              state_d = PRESS_DB;
              db_d    = DBW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (match) begin
            if (db_n == DBW'(DEBOUNCE_FRAMES)) begin
              push_d  = 1'b1;
              state_d = HELD;
              db_d    = '0;
              held_d  = '0;
              rate_d  = '0;
            end else begin
              db_d = db_n;
            end
          end else begin
            state_d = IDLE;
            db_d    = '0;
          end
        end
        HELD: begin
          if (match) begin
            // Count up to the initial delay, then pace repeats with the rate counter
            if (held_q != HW'(REPEAT_DELAY)) begin
              held_d = held_q + HW'(1);
              if (held_d == HW'(REPEAT_DELAY)) begin
                fire   = 1'b1;
                rate_d = '0;
              end
            end else if (rate_n == RW'(REPEAT_RATE)) begin
              fire   = 1'b1;
              rate_d = '0;
            end else begin
              rate_d = rate_n;
            end
            push_d     = fire && repeat_en;
            push_rep_d = 1'b1;
          end else if (DEBOUNCE_FRAMES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = RELEASE_DB;
            db_d    = DBW'(1);
          end
        end
        RELEASE_DB: begin
          if (match) begin
            state_d = HELD;
            db_d    = '0;
          end else if (db_n == DBW'(DEBOUNCE_FRAMES)) begin
            state_d = IDLE;
            db_d    = '0;
          end else begin
            db_d = db_n;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Event FIFO: a push held while full is dropped unless the head leaves this cycle
  always_comb begin
    pop      = (cnt_q != '0) && evt.key_ready;
    full     = (cnt_q == FW'(FIFO_DEPTH));
    wr_en    = push_q && (!full || pop);
    ovf_d    = push_q && full && !pop;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + FW'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - FW'(1);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = {push_rep_q, push_code_q};
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q     <= '0;
      col_s2_q     <= '0;
      div_q        <= '0;
      row_idx_q    <= '0;
      frame_n_q    <= 2'd0;
      frame_code_q <= '0;
      state_q      <= IDLE;
      cand_q       <= '0;
      db_q         <= '0;
      held_q       <= '0;
      rate_q       <= '0;
      push_q       <= 1'b0;
      multi_q      <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      col_s1_q     <= col_s1_d;
      col_s2_q     <= col_s2_d;
      div_q        <= div_d;
      row_idx_q    <= row_idx_d;
      frame_n_q    <= frame_n_d;
      frame_code_q <= frame_code_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      db_q         <= db_d;
      held_q       <= held_d;
      rate_q       <= rate_d;
      push_q       <= push_d;
      multi_q      <= multi_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Event payload and FIFO storage carry no reset; validity comes from push_q / cnt_q
  always_ff @(posedge clk) begin
    push_code_q <= push_code_d;
    push_rep_q  <= push_rep_d;
    mem_q       <= mem_d;
  end

  assign evt.key_valid  = (cnt_q != '0);
  assign evt.key_code   = evt.key_valid ? mem_q[rd_ptr_q][CW-1:0] : '0;
  assign evt.key_repeat = evt.key_valid ? mem_q[rd_ptr_q][CW] : 1'b0;
  assign fifo_count     = cnt_q;
  assign overflow       = ovf_q;
  assign multi_key      = multi_q;
endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan (4x4, 4-cycle slots, 16-cycle frames).
module tb_keypad_matrix_scan;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keyb_row;
  logic [3:0]  keyb_col;
  logic        repeat_en;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        multi_key;
  logic [15:0] keys;

  int n_vec = 0;
  int n_err = 0;
  int n_multi = 0;
  int n_ovf = 0;
  int ev_code[$];
  int ev_rep[$];

  keypad_matrix_scan_if #(.CW(4)) evt ();

  keypad_matrix_scan #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keyb_row(keyb_row), .keyb_col(keyb_col),
    .repeat_en(repeat_en), .evt(evt), .fifo_count(fifo_count),
    .overflow(overflow), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven low
  always_comb begin
    keyb_col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !keyb_row[r]) keyb_col[c] = 1'b0;
  end

  // Consumer-side monitor: log accepted events and status pulses mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt.key_valid && evt.key_ready) begin
        ev_code.push_back(int'(evt.key_code));
        ev_rep.push_back(int'(evt.key_repeat));
      end
      if (multi_key) n_multi++;
      if (overflow)  n_ovf++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] code_at(input int i);
    return (i < ev_code.size()) ? 32'(ev_code[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rep_at(input int i);
    return (i < ev_rep.size()) ? 32'(ev_rep[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int b;
    int mb;
    int ob;
    int codes[5];
    codes = '{1, 2, 4, 5, 6};
    rst_n = 1'b0;
    keys = '0;
    repeat_en = 1'b0;
    evt.key_ready = 1'b1;
    step(3);

    check("rst_row",   32'(keyb_row), 32'hE);
    check("rst_valid", 32'(evt.key_valid), 0);
    check("rst_code",  32'(evt.key_code), 0);
    check("rst_rep",   32'(evt.key_repeat), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_multi", 32'(multi_key), 0);

    // Single key r2c1 held 10 frames; event appears 2 clk after third frame end
    keys[9] = 1'b1;
    rst_n = 1'b1;
    step(48);
    check("hold9_pre_valid", 32'(evt.key_valid), 0);
    step(1);
    check("hold9_valid", 32'(evt.key_valid), 1);
    check("hold9_code",  32'(evt.key_code), 9);
    check("hold9_rep",   32'(evt.key_repeat), 0);
    check("hold9_count", 32'(fifo_count), 1);
    step(16*7 - 1);
    keys = '0;
    step(64);
    check("hold9_events", 32'(ev_code.size()), 1);
    check("hold9_ev_code", code_at(0), 9);
    check("hold9_ev_rep",  rep_at(0), 0);

    // Bouncing r0c3: only the third stable frame produces the event
    b = ev_code.size();
    keys[3] = 1'b1; step(16);
    keys = '0;      step(16);
    keys[3] = 1'b1; step(16);
    keys = '0;      step(16);
    keys[3] = 1'b1; step(48);
    check("bounce_pre_valid", 32'(evt.key_valid), 0);
    check("bounce_pre_events", 32'(ev_code.size() - b), 0);
    step(1);
    check("bounce_valid", 32'(evt.key_valid), 1);
    check("bounce_code",  32'(evt.key_code), 3);
    step(31);
    keys = '0;
    step(64);
    check("bounce_events", 32'(ev_code.size() - b), 1);
    check("bounce_ev_code", code_at(b), 3);
    check("bounce_ev_rep",  rep_at(b), 0);

    // Two keys together: multi_key every frame, no event
    b = ev_code.size();
    mb = n_multi;
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    step(96);
    check("multi_valid", 32'(evt.key_valid), 0);
    keys = '0;
    step(32);
    check("multi_pulses", 32'(n_multi - mb), 6);
    check("multi_events", 32'(ev_code.size() - b), 0);

    // Auto-repeat on r3c3: initial press then repeats at held frames 4, 6, 8
    b = ev_code.size();
    repeat_en = 1'b1;
    keys[15] = 1'b1;
    step(16*12);
    keys = '0;
    step(64);
    repeat_en = 1'b0;
    check("rpt_events", 32'(ev_code.size() - b), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rpt_code%0d", i), code_at(b + i), 15);
      check($sformatf("rpt_flag%0d", i), rep_at(b + i), (i == 0) ? 0 : 1);
    end

    // FIFO fill with consumer stalled: fifth event overflows and is dropped
    b = ev_code.size();
    ob = n_ovf;
    evt.key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      keys = '0;
      keys[codes[k]] = 1'b1;
      step(64);
      keys = '0;
      step(64);
    end
    check("full_count", 32'(fifo_count), 4);
    check("full_ovf_pulses", 32'(n_ovf - ob), 1);
    check("full_valid", 32'(evt.key_valid), 1);
    check("full_head", 32'(evt.key_code), 1);
    evt.key_ready = 1'b1;
    step(6);
    check("drain_events", 32'(ev_code.size() - b), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_code%0d", i), code_at(b + i), 32'(codes[i]));
    check("drain_count", 32'(fifo_count), 0);
    check("drain_valid", 32'(evt.key_valid), 0);

    // Reset while HELD with two queued events, key kept pressed through reset
    evt.key_ready = 1'b0;
    repeat_en = 1'b1;
    keys[7] = 1'b1;
    step(16*8);
    check("pre_rst_count", 32'(fifo_count), 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(evt.key_valid), 0);
    check("mid_rst_code",  32'(evt.key_code), 0);
    check("mid_rst_rep",   32'(evt.key_repeat), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_ovf",   32'(overflow), 0);
    check("mid_rst_multi", 32'(multi_key), 0);
    check("mid_rst_row",   32'(keyb_row), 32'hE);
    repeat_en = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(48);
    check("post_rst_pre_count", 32'(fifo_count), 0);
    step(1);
    check("post_rst_count", 32'(fifo_count), 1);
    check("post_rst_code",  32'(evt.key_code), 7);
    check("post_rst_rep",   32'(evt.key_repeat), 0);
    keys = '0;
    step(64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_matrix_scan.md
KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of driven keypad rows (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of sensed keypad columns (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clk cycles per row slot (>=4).
REQ-004 SHALL have parameter DEBOUNCE_FRAMES, default 3, consecutive identical frames needed to accept a press or a release (>=1).
REQ-005 SHALL have parameters REPEAT_DELAY, default 16, and REPEAT_RATE, default 4, both in frames (>=1).
REQ-006 SHALL have parameter FIFO_DEPTH, default 8, event FIFO depth (power of two, >=2); CW = $clog2(ROWS*COLS).
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port keyb_row, output, ROWS, one-hot active-low row drive.
REQ-010 SHALL have port keyb_col, input, COLS, asynchronous active-low column sense.
REQ-011 SHALL have port repeat_en, input, 1, enables auto-repeat events.
REQ-012 SHALL have port key_code, output, CW, FIFO head code = row*COLS+col.
REQ-013 SHALL have port key_repeat, output, 1, FIFO head is a repeat event (0 = initial press).
REQ-014 SHALL have port key_valid, output, 1, FIFO non-empty.
REQ-015 SHALL have port key_ready, input, 1, consumer accepts the head.
REQ-016 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, stored events.
REQ-017 SHALL have ports overflow and multi_key, outputs, 1 each, one-cycle status pulses.

Function
REQ-018 SHALL pass keyb_col through a 2-flop synchroniser before any use.
REQ-019 SHALL drive the active row low for SCAN_DIV cycles, then advance the row index, wrapping ROWS-1 -> 0; one frame = ROWS*SCAN_DIV cycles.
REQ-020 SHALL sample the synchronised columns only in the last cycle of each row slot.
REQ-021 SHALL classify each frame at its end as NONE (0 keys), SINGLE(code) (exactly 1 key) or MULTI (>=2 keys); MULTI SHALL pulse multi_key and count as NONE for the FSM.
REQ-022 SHALL implement FSM states IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-023 IDLE: SINGLE(c) -> PRESS_DB with candidate c, count 1; NONE -> stay.
REQ-024 PRESS_DB: SINGLE(same c) increments count; at count == DEBOUNCE_FRAMES push {c, repeat=0}, go to HELD; any other frame class -> IDLE.
REQ-025 HELD: SINGLE(c) increments held-frame counter; a frame with any other class -> RELEASE_DB, count 1.
REQ-026 HELD with repeat_en=1: push {c, repeat=1} when held frames == REPEAT_DELAY, then every REPEAT_RATE frames; repeat_en=0 SHALL suppress pushes without resetting the counter.
REQ-027 RELEASE_DB: non-SINGLE(c) frames increment count; at DEBOUNCE_FRAMES -> IDLE; SINGLE(c) -> HELD with held counter preserved.
REQ-028 A different key held after the original SHALL be reported only after release completes and a fresh PRESS_DB passes.
REQ-029 A push SHALL make key_valid visible 2 clk after the frame-end sample edge.
REQ-030 Pop SHALL occur on a cycle with key_valid && key_ready; key_code/key_repeat SHALL present the next entry on the following cycle.
REQ-031 Push when full and no pop SHALL drop the new event, pulse overflow and leave contents unchanged.
REQ-032 Simultaneous push and pop when full SHALL accept the push; fifo_count unchanged.
REQ-033 key_ready while empty SHALL have no effect; FIFO order SHALL be strictly first-in first-out.

Reset
REQ-034 While rst_n=0: keyb_row = all ones except bit 0 low, row index 0, FSM IDLE, all counters 0, synchroniser flops 0, FIFO empty.
REQ-035 While rst_n=0: key_valid=0, key_code=0, key_repeat=0, fifo_count=0, overflow=0, multi_key=0.
REQ-036 Reset asserted mid-operation SHALL discard pending events; a key still held after release SHALL be re-debounced as a new press.

Verification (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3, FIFO_DEPTH=4)
REQ-037 Hold r2c1 for 10 frames, repeat_en=0, key_ready=1 -> exactly one event, code 9, repeat 0.
REQ-038 Toggle r0c3 each frame for 4 frames, then hold 5 frames -> one event, code 3, after the 3rd stable frame.
REQ-039 Hold r0c0 and r1c1 together for 6 frames -> multi_key pulses every frame, no event.
REQ-040 repeat_en=1, REPEAT_DELAY=4, REPEAT_RATE=2, hold r3c3 for 12 frames -> 4 events, code 15, repeat flags 0,1,1,1.
REQ-041 key_ready=0, press/release codes 1,2,4,5,6 in turn -> fifo_count=4, one overflow pulse on 5th, then pops yield 1,2,4,5.
REQ-042 Assert rst_n=0 while in HELD with 2 events queued -> all outputs at reset values; after rst_n=1 with key held, one new event after 3 frames.
